// File: rtl/axis_fifo_arbiter.sv
// Round-robin, packet-locked arbiter that funnels NUM_REQ AXI-Stream requesters
// into one command FIFO, tagging each beat with {src_id, last} and capping packets at MAX_BEATS.

module axis_fifo_arbiter_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2,
    parameter int LANE       = 0
) (
    input  logic                  xfer,
    input  logic [ID_WIDTH-1:0]   grant_id,
    input  logic                  fifo_full,
    input  logic                  tvalid,
    input  logic                  tlast,
    input  logic [DATA_WIDTH-1:0] tdata,
    output logic                  tready,
    output logic                  vld_sel,
    output logic                  last_sel,
    output logic [DATA_WIDTH-1:0] data_sel
);
    logic sel;

    // Each lane contributes only while it owns the grant, so the top can OR-reduce.
    assign sel      = xfer && (grant_id == ID_WIDTH'(LANE));
    assign tready   = sel & ~fifo_full;
    assign vld_sel  = sel & tvalid;
    assign last_sel = sel & tlast;
    assign data_sel = sel ? tdata : '0;
endmodule

module axis_fifo_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BEATS  = 8,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             arstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_REQ-1:0]               s_tvalid,
    input  logic [NUM_REQ-1:0]               s_tlast,
    output logic [NUM_REQ-1:0]               s_tready,
    output logic                             fifo_push,
    output logic [ID_WIDTH+DATA_WIDTH:0]     fifo_data,
    input  logic                             fifo_full,
    output logic                             grant_valid,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             pkt_trunc
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                               state;
    logic [CNT_W-1:0]                     beat_cnt;
    logic [ID_WIDTH-1:0]                  last_grant;
    logic [ID_WIDTH-1:0]                  winner;
    logic                                 xfer;
    logic                                 sel_vld;
    logic                                 sel_last;
    logic                                 last_o;
    logic [DATA_WIDTH-1:0]                sel_data;
    logic [NUM_REQ-1:0]                   lane_vld;
    logic [NUM_REQ-1:0]                   lane_last;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   lane_data;

    assign xfer = (state == XFER);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        axis_fifo_arbiter_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .LANE       (i)
        ) u_lane (
            .xfer      (xfer),
            .grant_id  (grant_id),
            .fifo_full (fifo_full),
            .tvalid    (s_tvalid[i]),
            .tlast     (s_tlast[i]),
            .tdata     (s_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .tready    (s_tready[i]),
            .vld_sel   (lane_vld[i]),
            .last_sel  (lane_last[i]),
            .data_sel  (lane_data[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) sel_data |= lane_data[i];
    end

    assign sel_vld   = |lane_vld;
    assign sel_last  = |lane_last;
    // Watchdog forces last on the MAX_BEATS-th beat so no requester hogs the FIFO.
    assign last_o    = xfer & (sel_last | (beat_cnt == CNT_W'(MAX_BEATS - 1)));
    assign fifo_push = sel_vld & ~fifo_full;
    assign fifo_data = {grant_id, last_o, sel_data};

    // Search starts one past the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && s_tvalid[idx]) begin
                winner = ID_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            pkt_trunc   <= 1'b0;
            beat_cnt    <= '0;
            last_grant  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            pkt_trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    // A stalled or idle granted requester simply holds the lock.
                    if (fifo_push) begin
                        if (last_o) begin
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            beat_cnt    <= '0;
                            pkt_trunc   <= ~sel_last;
                            state       <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Directed bench for axis_fifo_arbiter: queue-fed requesters, expected beats in a
// scoreboard, and a negedge monitor that pops and compares on every FIFO push.

module tb_axis_fifo_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int IW = 2;
    localparam int FW = IW + 1 + DW;

    logic              clk   = 1'b0;
    logic              arstn = 1'b0;
    logic [NR*DW-1:0]  s_tdata  = '0;
    logic [NR-1:0]     s_tvalid = '0;
    logic [NR-1:0]     s_tlast  = '0;
    logic [NR-1:0]     s_tready;
    logic              fifo_push;
    logic [FW-1:0]     fifo_data;
    logic              fifo_full = 1'b0;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;
    logic              pkt_trunc;

    always #5 clk = ~clk;

    axis_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .fifo_push   (fifo_push),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pkt_trunc   (pkt_trunc)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            trunc_cnt = 0;
    string         phase = "init";
    logic [FW-1:0] expq[$];
    int            push_cyc[$];
    logic [DW:0]   txq[NR][$];
    logic [NR-1:0] fire_q = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h want %0h", phase, nm, act, exp);
        end
    endtask

    task automatic exp_push(int id, bit last, int data);
        expq.push_back({IW'(id), last, DW'(data)});
    endtask

    task automatic send(int r, int n, int base, bit last_end);
        for (int k = 0; k < n; k++)
            txq[r].push_back({(last_end && k == n - 1), DW'(base + k)});
    endtask

    function automatic bit txq_empty();
        for (int i = 0; i < NR; i++) if (txq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(int budget);
        int k;
        k = 0;
        while (!(expq.size() == 0 && txq_empty() && !grant_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(k < budget), 32'd1);
    endtask

    // Asserted from a negedge; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        arstn = 1'b0;
        #1;
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id",    32'(grant_id),    32'd0);
        chk("rst_pkt_trunc",   32'(pkt_trunc),   32'd0);
        chk("rst_s_tready",    32'(s_tready),    32'd0);
        chk("rst_fifo_push",   32'(fifo_push),   32'd0);
        chk("rst_exp_left",    32'(expq.size()), 32'd0);
        for (int i = 0; i < NR; i++) txq[i].delete();
        repeat (2) @(negedge clk);
        arstn = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        fire_q <= s_tvalid & s_tready;
    end

    // Requester model: pop on handshake, hold the head beat stable otherwise.
    always begin
        logic [DW:0] b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire_q[i] && txq[i].size() > 0) b = txq[i].pop_front();
            if (txq[i].size() > 0) begin
                b = txq[i][0];
                s_tvalid[i]          = 1'b1;
                s_tlast[i]           = b[DW];
                s_tdata[i*DW +: DW]  = b[DW-1:0];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tlast[i]           = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
            end
        end
    end

    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (pkt_trunc) trunc_cnt++;
        if (fifo_push) begin
            push_cyc.push_back(cyc);
            if (expq.size() == 0) chk("unexpected_push", 32'(fifo_push), 32'd0);
            else begin
                e = expq.pop_front();
                chk("push_data", 32'(fifo_data), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        @(negedge clk);
        do_reset();

        phase = "single";
        @(negedge clk);
        t0 = cyc;
        push_cyc.delete();
        send(2, 3, 'hA1, 1'b1);
        exp_push(2, 0, 'hA1); exp_push(2, 0, 'hA2); exp_push(2, 1, 'hA3);
        wait_drain(40);
        chk("first_push_cyc", 32'(push_cyc[0]), 32'(t0 + 2));
        chk("second_push_cyc", 32'(push_cyc[1]), 32'(t0 + 3));
        chk("third_push_cyc", 32'(push_cyc[2]), 32'(t0 + 4));
        chk("grant_id_hold", 32'(grant_id), 32'd2);
        chk("trunc_cnt", 32'(trunc_cnt), 32'd0);

        phase = "fair";
        @(negedge clk);
        do_reset();
        @(negedge clk);
        send(0, 1, 'hC0, 1'b1); send(0, 1, 'hC4, 1'b1);
        send(1, 1, 'hC1, 1'b1); send(1, 1, 'hC5, 1'b1);
        send(2, 1, 'hC2, 1'b1); send(3, 1, 'hC3, 1'b1);
        exp_push(0, 1, 'hC0); exp_push(1, 1, 'hC1); exp_push(2, 1, 'hC2);
        exp_push(3, 1, 'hC3); exp_push(0, 1, 'hC4); exp_push(1, 1, 'hC5);
        wait_drain(60);
        chk("trunc_cnt", 32'(trunc_cnt), 32'd0);

        phase = "lock";
        @(negedge clk);
        send(1, 4, 'hD1, 1'b1);
        exp_push(1, 0, 'hD1); exp_push(1, 0, 'hD2); exp_push(1, 0, 'hD3); exp_push(1, 1, 'hD4);
        exp_push(0, 1, 'hE0);
        repeat (2) @(negedge clk);
        chk("ready_granted", 32'(s_tready), 32'b0010);
        send(0, 1, 'hE0, 1'b1);
        repeat (2) @(posedge clk);
        #1 fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_tready", 32'(s_tready), 32'd0);
            chk("full_push", 32'(fifo_push), 32'd0);
            chk("full_grant_id", 32'(grant_id), 32'd1);
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_drain(60);
        chk("trunc_cnt", 32'(trunc_cnt), 32'd0);

        phase = "trunc";
        @(negedge clk);
        send(3, 10, 'hF0, 1'b1);
        for (int k = 0; k < 8; k++) exp_push(3, (k == 7), 'hF0 + k);
        exp_push(3, 0, 'hF8); exp_push(3, 1, 'hF9);
        wait_drain(80);
        chk("trunc_cnt", 32'(trunc_cnt), 32'd1);

        phase = "midreset";
        trunc_cnt = 0;
        @(negedge clk);
        send(1, 1, 'h0111, 1'b1);
        exp_push(1, 1, 'h0111);
        wait_drain(40);
        @(negedge clk);
        send(0, 4, 'h0220, 1'b1);
        exp_push(0, 0, 'h0220); exp_push(0, 0, 'h0221);
        repeat (3) @(negedge clk);
        #1;
        do_reset();
        @(negedge clk);
        send(2, 1, 'h0330, 1'b1);
        send(0, 1, 'h0300, 1'b1);
        exp_push(0, 1, 'h0300); exp_push(2, 1, 'h0330);
        wait_drain(40);
        chk("trunc_cnt", 32'(trunc_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_fifo_arbiter.md
Name: axis_fifo_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one command sync FIFO between NUM_REQ AXI-Stream requesters, e.g. several register-access clients feeding the single I2C master command path.
- Each accepted beat is pushed into the FIFO tagged with its source ID and a last flag.
- A beat watchdog truncates runaway packets so no requester can hold the FIFO indefinitely.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, payload width per beat.
- MAX_BEATS, 8, maximum beats per granted packet before forced release (>=1).
- ID_WIDTH, $clog2(NUM_REQ), source ID width (derived, localparam).

Ports:
- clk  in  1  system clock.
- arstn  in  1  asynchronous active-low reset.
- s_tdata  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_REQ  per-requester valid.
- s_tlast  in  NUM_REQ  per-requester end of packet.
- s_tready  out  NUM_REQ  per-requester ready.
- fifo_push  out  1  FIFO write strobe.
- fifo_data  out  ID_WIDTH+1+DATA_WIDTH  {src_id, last, tdata}.
- fifo_full  in  1  FIFO full; must depend only on FIFO state, never combinationally on fifo_push.
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  ID_WIDTH  current or last granted requester.
- pkt_trunc  out  1  one-cycle pulse when a packet is cut at MAX_BEATS.

Behaviour:
- Reset values: FSM=IDLE, grant_valid=0, grant_id=0, pkt_trunc=0, s_tready=0, fifo_push=0, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, XFER.
- IDLE:
  - s_tready all 0; fifo_push=0.
  - If any s_tvalid: winner is the first set bit searching last_grant+1, last_grant+2, ... with modulo-NUM_REQ wrap.
  - Register grant_id=winner, grant_valid=1, beat_cnt=0; go to XFER.
  - Arbitration latency: 1 cycle from valid to grant.
- XFER, granted requester g:
  - s_tready[g] = !fifo_full; all other s_tready bits 0.
  - fifo_push = s_tvalid[g] & !fifo_full (combinational). fifo_data = {g, last_o, s_tdata[g]}.
  - last_o = s_tlast[g] | (beat_cnt == MAX_BEATS-1).
  - Each pushed beat increments beat_cnt; width is $clog2(MAX_BEATS+1).
  - When a beat pushes with last_o=1: last_grant<=g, grant_valid<=0, go to IDLE. No back-to-back grant, so at least 1 idle cycle between packets.
  - If that beat had s_tlast[g]=0, pulse pkt_trunc for the cycle after the push. The requester's remaining beats re-arbitrate as a new packet.
- Grant lock:
  - Once granted, g keeps the grant until last_o is pushed, regardless of other requesters.
  - s_tvalid[g] dropping mid-packet holds the grant, with no push and no timeout.
- fifo_full:
  - While full, no push and s_tready=0; beat_cnt is frozen; state is held.
  - Deassertion resumes the transfer in the same cycle.
- AXIS rule: requesters must hold tdata/tlast stable while tvalid & !tready. The arbiter never drops or duplicates a beat.
- Async reset mid-packet:
  - Immediate return to reset values; the partial packet already in the FIFO is not retracted.
  - Clearing the FIFO is the system's responsibility, since it shares arstn.
- grant_id holds its last value in IDLE.

Test Plan:
- Single requester: NUM_REQ=4, req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd) -> 1 idle cycle, then 3 consecutive pushes of fifo_data {2,0,A1},{2,0,A2},{2,1,A3}; grant_valid drops after beat 3.
- Fairness: all 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0,1; every req served once per 4 packets.
- Lock and backpressure:
  - req 1 starts a 4-beat packet; req 0 asserts valid mid-packet; fifo_full=1 for 3 cycles after beat 2.
  - Required: no push and s_tready=0 while full; req 1 completes beats 3-4 before req 0 is granted.
- Truncation: MAX_BEATS=8, req 3 sends 10 beats with tlast on beat 10 -> beat 8 pushed with last=1, pkt_trunc pulses once, then beats 9-10 form a new 2-beat packet.
- Reset mid-packet: arstn low during beat 2 of req 0 -> all outputs 0 asynchronously; after release, req 0 has highest priority again.
